memory_1rw_initiator: RTL

MEMORY_1RW_INITIATOR -- requirements
Module: memory_1rw_initiator

---
 rtl/memory_1rw_initiator.sv | 119 +++++++++++
 1 files changed

// File: rtl/memory_1rw_initiator.sv
// Request/response front end for a single-port 1RW memory macro. Issues
// accepted requests straight to the memory and queues read data in order.
module memory_1rw_initiator #(
    parameter int unsigned DATAW        = 32,
    parameter int unsigned WORDW        = 1024,
    parameter int unsigned ADDRW        = $clog2(WORDW),
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned RSP_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [ADDRW-1:0] req_addr,
    input  logic [DATAW-1:0] req_data,
    input  logic [DATAW-1:0] req_mask,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DATAW-1:0] rsp_data,
    output logic             mem_me,
    output logic             mem_we,
    output logic [DATAW-1:0] mem_wem,
    output logic [DATAW-1:0] mem_d,
    output logic [ADDRW-1:0] mem_adr,
    input  logic [DATAW-1:0] mem_q,
    output logic             busy
);

    localparam int unsigned CNTW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTRW = $clog2(RSP_DEPTH);
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(RSP_DEPTH);
    localparam logic [PTRW-1:0] LAST_C  = PTRW'(RSP_DEPTH - 1);

    logic [CNTW-1:0]         outstanding;
    logic [CNTW-1:0]         fifo_count;
    logic [PTRW-1:0]         wr_ptr;
    logic [PTRW-1:0]         rd_ptr;
    logic [READ_LATENCY-1:0] vld_sr;
    logic [DATAW-1:0]        fifo_mem [RSP_DEPTH];

    logic accept;
    logic rd_accept;
    logic wr_accept;
    logic fifo_push;
    logic fifo_pop;

    // Gating with rst_n keeps every issue-side output quiet while reset is held.
    assign req_ready = rst_n && (outstanding < DEPTH_C);
    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_write;
    assign wr_accept = accept && req_write;

    assign mem_me  = accept;
    assign mem_we  = wr_accept;
    assign mem_adr = accept    ? req_addr : '0;
    assign mem_d   = wr_accept ? req_data : '0;
    assign mem_wem = wr_accept ? req_mask : '0;

    assign fifo_push = vld_sr[READ_LATENCY-1];
    assign rsp_valid = (fifo_count != '0);
    assign fifo_pop  = rsp_valid && rsp_ready;
    assign rsp_data  = rsp_valid ? fifo_mem[rd_ptr] : '0;
    assign busy      = (outstanding != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({rd_accept, fifo_pop})
                2'b10:   outstanding <= outstanding + CNTW'(1);
                2'b01:   outstanding <= outstanding - CNTW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= rd_accept;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + PTRW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + PTRW'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + CNTW'(1);
                2'b01:   fifo_count <= fifo_count - CNTW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= mem_q;
        end
    end

    // Space is reserved at accept time, so a push never meets a full queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && (fifo_count == DEPTH_C) && !fifo_pop));

endmodule
